// File: rtl/lcd_write_arbiter.sv
// Arbiter sharing one SPI LCD writer between NUM_CH requesters.
// Each channel has a 1-deep holding register; one word per grant.
module lcd_write_arbiter #(
    parameter int NUM_CH      = 3,
    parameter int DATA_W      = 9,
    parameter int ARB_MODE    = 1,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst,
    input  logic                     init_done,
    input  logic [NUM_CH*DATA_W-1:0] req_data,
    input  logic [NUM_CH-1:0]        req_en,
    input  logic [NUM_CH-1:0]        req_lock,
    input  logic                     wr_done,
    output logic [DATA_W-1:0]        spi_data,
    output logic                     en_write,
    output logic [NUM_CH-1:0]        grant,
    output logic [NUM_CH-1:0]        ch_done,
    output logic                     busy,
    output logic [1:0]               err
);

    localparam int IDX_W = $clog2(NUM_CH);
    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } state_t;

    state_t               state;
    logic [NUM_CH-1:0]    pending;
    logic [NUM_CH-1:0]    eligible;
    logic [DATA_W-1:0]    hold [NUM_CH];
    logic [IDX_W-1:0]     win_idx;
    logic [IDX_W-1:0]     rr_ptr;
    logic [IDX_W-1:0]     pick_idx;
    logic                 pick_vld;
    logic [CNT_W-1:0]     to_cnt;
    logic                 timeout_hit;
    logic                 ovf_err;
    logic                 to_err;

    assign err = {to_err, ovf_err};

    // A held lock keeps the bus with the current owner only.
    always_comb begin
        eligible = pending;
        if (!init_done)
            eligible = eligible & NUM_CH'(1);
        if (|(grant & req_lock))
            eligible = eligible & grant;
    end

    // Descending scans so the last hit is the highest-priority candidate.
    always_comb begin
        int j;
        pick_vld = 1'b0;
        pick_idx = '0;
        j        = 0;
        if (ARB_MODE == 0) begin
            for (int i = NUM_CH - 1; i >= 0; i--) begin
                if (eligible[i]) begin
                    pick_vld = 1'b1;
                    pick_idx = IDX_W'(i);
                end
            end
        end else begin
            for (int k = NUM_CH; k >= 1; k--) begin
                j = int'(rr_ptr) + k;
                if (j >= NUM_CH)
                    j = j - NUM_CH;
                if (eligible[j]) begin
                    pick_vld = 1'b1;
                    pick_idx = IDX_W'(j);
                end
            end
        end
    end

    assign timeout_hit = (TIMEOUT_CYC > 0) &&
                         (to_cnt == CNT_W'(TIMEOUT_CYC - 1));

    // A new word from the winner on its issue cycle refills the slot.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            pending <= '0;
            ovf_err <= 1'b0;
            for (int i = 0; i < NUM_CH; i++)
                hold[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (req_en[i]) begin
                    if (pending[i] &&
                        !(state == ISSUE && win_idx == IDX_W'(i))) begin
                        ovf_err <= 1'b1;
                    end else begin
                        pending[i] <= 1'b1;
                        hold[i]    <= req_data[i*DATA_W +: DATA_W];
                    end
                end else if (state == ISSUE && win_idx == IDX_W'(i)) begin
                    pending[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state    <= IDLE;
            en_write <= 1'b0;
            ch_done  <= '0;
            busy     <= 1'b0;
            grant    <= '0;
            spi_data <= '0;
            win_idx  <= '0;
            rr_ptr   <= IDX_W'(NUM_CH - 1);
            to_cnt   <= '0;
            to_err   <= 1'b0;
        end else begin
            en_write <= 1'b0;
            ch_done  <= '0;
            unique case (state)
                IDLE: begin
                    if (pick_vld) begin
                        state   <= ISSUE;
                        busy    <= 1'b1;
                        win_idx <= pick_idx;
                        rr_ptr  <= pick_idx;
                        grant   <= NUM_CH'(1) << pick_idx;
                    end
                end
                ISSUE: begin
                    state    <= WAIT;
                    en_write <= 1'b1;
                    spi_data <= hold[win_idx];
                    to_cnt   <= '0;
                end
                WAIT: begin
                    if (wr_done) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        ch_done <= grant;
                        to_cnt  <= '0;
                    end else if (timeout_hit) begin
                        state  <= IDLE;
                        busy   <= 1'b0;
                        to_err <= 1'b1;
                        to_cnt <= '0;
                    end else if (TIMEOUT_CYC > 0) begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_write_arbiter.sv
// Scoreboard bench for lcd_write_arbiter (3 channels, round-robin,
// 16-cycle timeout). Monitor checks every en_write and ch_done.
module tb_lcd_write_arbiter;

    logic        clk = 1'b0;
    logic        sys_rst;
    logic        init_done;
    logic [26:0] req_data;
    logic [2:0]  req_en;
    logic [2:0]  req_lock;
    logic        wr_done;
    logic [8:0]  spi_data;
    logic        en_write;
    logic [2:0]  grant;
    logic [2:0]  ch_done;
    logic        busy;
    logic [1:0]  err;

    typedef struct {
        logic [8:0] data;
        logic [2:0] gnt;
    } exp_t;

    exp_t       exp_wr[$];
    logic [2:0] exp_done[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    bit         resp_on = 1'b0;

    lcd_write_arbiter #(
        .NUM_CH(3), .DATA_W(9), .ARB_MODE(1), .TIMEOUT_CYC(16)
    ) dut (
        .sys_clk(clk), .sys_rst(sys_rst), .init_done(init_done),
        .req_data(req_data), .req_en(req_en), .req_lock(req_lock),
        .wr_done(wr_done), .spi_data(spi_data), .en_write(en_write),
        .grant(grant), .ch_done(ch_done), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_wr(input logic [8:0] d, input logic [2:0] g,
                             input bit done);
        exp_t e;
        e.data = d;
        e.gnt  = g;
        exp_wr.push_back(e);
        if (done)
            exp_done.push_back(g);
    endtask

    task automatic pulse(input logic [2:0] en, input logic [8:0] d0,
                         input logic [8:0] d1, input logic [8:0] d2);
        req_data = {d2, d1, d0};
        req_en   = en;
        tick();
        req_en   = 3'b000;
    endtask

    task automatic wait_en();
        int n = 0;
        while (!en_write && n < 20) begin
            tick();
            n++;
        end
        chk("en_write_seen", en_write, 1);
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_wr.size() != 0 || exp_done.size() != 0 || busy)
               && n < 200) begin
            tick();
            n++;
        end
        chk("drain_done", n < 200, 1);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents an output.
    initial begin
        exp_t e;
        logic [2:0] g;
        forever begin
            @(negedge clk);
            if (!sys_rst) begin
                if (en_write) begin
                    if (exp_wr.size() == 0) begin
                        chk("unexpected_en_write", 1, 0);
                    end else begin
                        e = exp_wr.pop_front();
                        chk("spi_data", spi_data, e.data);
                        chk("grant", grant, e.gnt);
                    end
                end
                if (ch_done != 3'b000) begin
                    if (exp_done.size() == 0) begin
                        chk("unexpected_ch_done", ch_done, 0);
                    end else begin
                        g = exp_done.pop_front();
                        chk("ch_done", ch_done, g);
                    end
                end
            end
        end
    end

    // SPI writer model: wr_done 4 cycles after each en_write.
    initial begin
        wr_done = 1'b0;
        forever begin
            @(negedge clk);
            if (en_write && resp_on) begin
                repeat (3) @(negedge clk);
                wr_done = 1'b1;
                @(negedge clk);
                wr_done = 1'b0;
            end
        end
    end

    initial begin
        sys_rst   = 1'b1;
        init_done = 1'b0;
        req_data  = '0;
        req_en    = '0;
        req_lock  = '0;
        repeat (2) tick();
        chk("rst_spi_data", spi_data, 0);
        chk("rst_en_write", en_write, 0);
        chk("rst_grant", grant, 0);
        chk("rst_ch_done", ch_done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        sys_rst = 1'b0;

        // init_done low: only ch0 served, ch1 waits
        resp_on = 1'b1;
        expect_wr(9'h0A5, 3'b001, 1);
        pulse(3'b011, 9'h0A5, 9'h1C3, 9'h000);
        wait_drain();
        repeat (10) tick();
        chk("init_ch1_held_busy", busy, 0);
        expect_wr(9'h1C3, 3'b010, 1);
        init_done = 1'b1;
        wait_drain();

        // round-robin order after reset, with latency check
        sys_rst = 1'b1;
        tick();
        sys_rst = 1'b0;
        expect_wr(9'h111, 3'b001, 1);
        expect_wr(9'h022, 3'b010, 1);
        expect_wr(9'h1F0, 3'b100, 1);
        pulse(3'b111, 9'h111, 9'h022, 9'h1F0);
        chk("lat_cyc0", en_write, 0);
        tick();
        chk("lat_cyc1", en_write, 0);
        tick();
        chk("lat_cyc2", en_write, 1);
        wait_drain();

        // overflow: second word dropped, first one sent
        init_done = 1'b0;
        pulse(3'b100, 9'h000, 9'h000, 9'h155);
        pulse(3'b100, 9'h000, 9'h000, 9'h0AA);
        chk("ovf_err", err, 2'b01);
        expect_wr(9'h155, 3'b100, 1);
        init_done = 1'b1;
        wait_drain();

        // ch1 lock: three words back-to-back, then ch2
        expect_wr(9'h101, 3'b010, 1);
        expect_wr(9'h102, 3'b010, 1);
        expect_wr(9'h103, 3'b010, 1);
        expect_wr(9'h0E7, 3'b100, 1);
        req_lock = 3'b010;
        pulse(3'b110, 9'h000, 9'h101, 9'h0E7);
        wait_en();
        pulse(3'b010, 9'h000, 9'h102, 9'h000);
        wait_en();
        pulse(3'b010, 9'h000, 9'h103, 9'h000);
        wait_en();
        req_lock = 3'b000;
        wait_drain();

        // timeout: wr_done withheld, no ch_done
        resp_on = 1'b0;
        expect_wr(9'h033, 3'b001, 0);
        pulse(3'b001, 9'h033, 9'h000, 9'h000);
        wait_en();
        repeat (15) tick();
        chk("to_busy_15", busy, 1);
        chk("to_err_15", err, 2'b01);
        tick();
        chk("to_busy_16", busy, 0);
        chk("to_err_16", err, 2'b11);
        repeat (4) tick();

        // reset during WAIT, then a stray wr_done
        expect_wr(9'h044, 3'b001, 0);
        pulse(3'b001, 9'h044, 9'h000, 9'h000);
        wait_en();
        tick();
        chk("wait_busy", busy, 1);
        sys_rst = 1'b1;
        tick();
        sys_rst = 1'b0;
        chk("mid_rst_spi_data", spi_data, 0);
        chk("mid_rst_grant", grant, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_err", err, 0);
        chk("mid_rst_en_write", en_write, 0);
        wr_done = 1'b1;
        tick();
        wr_done = 1'b0;
        tick();
        chk("stray_ch_done", ch_done, 0);
        repeat (5) tick();
        chk("stray_busy", busy, 0);

        // refill on the issue cycle is accepted without overflow
        resp_on = 1'b1;
        expect_wr(9'h1AB, 3'b001, 1);
        expect_wr(9'h0CD, 3'b001, 1);
        pulse(3'b001, 9'h1AB, 9'h000, 9'h000);
        tick();
        pulse(3'b001, 9'h0CD, 9'h000, 9'h000);
        chk("refill_en_write", en_write, 1);
        chk("refill_err", err, 0);
        wait_drain();
        chk("refill_err_end", err, 0);

        chk("wr_queue_empty", exp_wr.size(), 0);
        chk("done_queue_empty", exp_done.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "simulation time limit");
    end

endmodule

// File: doc/lcd_write_arbiter.md
LCD_WRITE_ARBITER -- requirements
Module: lcd_write_arbiter

Interface
REQ-001 SHALL provide parameter NUM_CH, default 3, number of requesting channels (legal 2..8).
REQ-002 SHALL provide parameter DATA_W, default 9, request word width (bit DATA_W-1 is the DC flag, lower bits are payload).
REQ-003 SHALL provide parameter ARB_MODE, default 1, arbitration policy (0 = fixed priority with ch0 highest, 1 = round-robin).
REQ-004 SHALL provide parameter TIMEOUT_CYC, default 4096, maximum wait for wr_done in cycles (0 = timeout disabled).
REQ-005 sys_clk  input  1  single clock; all logic is on its rising edge.
REQ-006 sys_rst  input  1  reset, synchronous, active-high.
REQ-007 init_done  input  1  LCD init complete; while low, only ch0 is eligible.
REQ-008 req_data  input  NUM_CH*DATA_W  per-channel word; channel i occupies bits [i*DATA_W +: DATA_W].
REQ-009 req_en  input  NUM_CH  per-channel one-cycle write strobe.
REQ-010 req_lock  input  NUM_CH  per-channel bus hold; the granted channel keeps exclusive access while its bit is high.
REQ-011 wr_done  input  1  one-cycle completion pulse from the SPI writer.
REQ-012 spi_data  output  DATA_W  word presented to the SPI writer.
REQ-013 en_write  output  1  one-cycle write strobe to the SPI writer.
REQ-014 grant  output  NUM_CH  one-hot owner of the current or last transfer.
REQ-015 ch_done  output  NUM_CH  one-cycle completion pulse returned to the owning channel.
REQ-016 busy  output  1  high in ISSUE and WAIT.
REQ-017 err  output  2  sticky error flags: bit0 = overflow, bit1 = timeout.

Function
REQ-018 Per channel, SHALL keep a 1-deep holding register and a pending bit.
- req_en[i] high: pending[i] is set and req_data slice i is latched into the holding register.
REQ-019 If req_en[i] is high while pending[i] is already set and not being cleared in that cycle, SHALL drop the new word, keep the old word, and set err[0].
REQ-020 FSM states SHALL be IDLE, ISSUE, WAIT.
- IDLE -> ISSUE when any eligible channel is pending.
- ISSUE -> WAIT always, after one cycle.
- WAIT -> IDLE on wr_done or on timeout.
REQ-021 Eligibility SHALL be decided as follows:
- a channel must be pending;
- while init_done is low, only ch0 is eligible;
- while the current owner's req_lock is high, only the owner is eligible.
REQ-022 Winner selection SHALL follow ARB_MODE:
- ARB_MODE 0: lowest eligible index wins.
- ARB_MODE 1: search starts at the index after the last served channel, wrapping from NUM_CH-1 to 0.
REQ-023 grant SHALL be registered on the IDLE->ISSUE edge and held until the next grant.
REQ-024 In ISSUE, SHALL drive en_write=1 for exactly one cycle with spi_data equal to the winner's held word, and clear the winner's pending bit.
REQ-025 A req_en from the winner in the same cycle its pending bit clears SHALL be accepted as a new pending word with no overflow.
REQ-026 spi_data SHALL hold its value from ISSUE until the next ISSUE.
REQ-027 In WAIT, a wr_done pulse SHALL produce ch_done[owner]=1 for exactly one cycle, on the cycle after wr_done; wr_done seen outside WAIT SHALL be ignored.
REQ-028 Latency from req_en sampled (cycle 0), with the FSM in IDLE and the channel eligible, to en_write high SHALL be 2 cycles.
- Minimum spacing between consecutive en_write pulses is 3 cycles after wr_done.
REQ-029 Timeout, when TIMEOUT_CYC > 0:
- a counter SHALL count cycles spent in WAIT;
- on reaching TIMEOUT_CYC, the FSM SHALL return to IDLE, set err[1], and issue no ch_done.
REQ-030 A req_lock deasserted during WAIT SHALL release the bus at the next IDLE.
REQ-031 Channels with no pending word SHALL never be granted, and no en_write SHALL issue with no pending word.

Reset
REQ-032 With sys_rst high at a clock edge, SHALL set:
- FSM to IDLE;
- all pending bits, err, and the timeout counter to 0;
- en_write, ch_done, and busy to 0;
- grant and spi_data to 0;
- the round-robin pointer to NUM_CH-1, so ch0 is searched first.
REQ-033 Reset mid-transfer SHALL abandon the transfer with no ch_done and discard all held words.

Verification
REQ-034 init_done=0; ch1 and ch0 both req_en -> only ch0 is served (spi_data = ch0 word, grant=001); ch1 stays pending until init_done=1.
REQ-035 ARB_MODE=1, NUM_CH=3; all three pend simultaneously, wr_done returned 4 cycles after each en_write -> service order ch0, ch1, ch2; en_write high 2 cycles after req_en for ch0.
REQ-036 ch1 holds req_lock=1 over 3 words while ch2 pends -> ch1's 3 words issue back-to-back; ch2 is granted only after the lock drops.
REQ-037 ch2 req_en twice while its first word is not yet issued -> err[0]=1 and the first word is the one sent.
REQ-038 TIMEOUT_CYC=16, wr_done withheld -> after 16 WAIT cycles, err[1]=1, busy=0, no ch_done.
REQ-039 sys_rst asserted during WAIT -> all outputs 0 next cycle; a subsequent wr_done produces no ch_done.
